// File: rtl/coreahblite_arb_pkg.sv
// Shared types and constants for the CoreAHBLite per-slave round-robin arbiter.
// Consumers: coreahblite_rr_picker, coreahblite_slave_rr_arbiter.
package coreahblite_arb_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int IDX_W       = 2;
    localparam int CNT_W       = 4;

    localparam logic [NUM_MASTERS-1:0] MASTER_NONE = 4'b0000;

    // Arbiter states; prefixed so they cannot collide with the LOCKED port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    // Index of the set bit in a one-hot master vector (0 when none is set).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (onehot[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/coreahblite_rr_picker.sv
// Combinational rotate-priority encoder: the first requester (ignoring
// excluded masters) found after ptr, wrapping, wins.
module coreahblite_rr_picker
    import coreahblite_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    input  logic [NUM_MASTERS-1:0] exclude,
    output logic [NUM_MASTERS-1:0] winner,
    output logic                   valid
);

    logic [NUM_MASTERS-1:0] cand;

    assign cand = req & ~exclude;

    // Scan ptr+1, ptr+2, ... ptr+NUM_MASTERS (mod NUM_MASTERS); first hit wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        winner = MASTER_NONE;
        valid  = 1'b0;
        idx    = ptr;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = ptr + IDX_W'(i);
            if (!valid && cand[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coreahblite_slave_rr_arbiter.sv
// Per-slave address-phase arbiter for the CoreAHBLite 4-master matrix.
// Round-robin between requesting masters, HMASTLOCK-aware locked sequences,
// re-arbitration only at address-phase boundaries (ADDRPHEND) or in IDLE.
// Optional build macro COREAHBLITE_ARB_QUOTA_EN: an owner may keep the slave
// for up to QUOTA consecutive address phases while others wait. Without it
// ownership rotates on every completed address phase if anyone else waits.
module coreahblite_slave_rr_arbiter
    import coreahblite_arb_pkg::*;
#(
    parameter int unsigned QUOTA = 4
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] MADDRSEL,
    input  logic [NUM_MASTERS-1:0] MLOCK,
    input  logic                   ADDRPHEND,
    output logic [NUM_MASTERS-1:0] MASTERADDRINPROG,
    output logic                   LOCKED
);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   locked_q;

    logic [NUM_MASTERS-1:0] pick;
    logic                   pick_valid;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   other_req;
    logic                   quota_left;
    logic                   load_one;  // new owner: quota count restarts at 1
    logic                   bump;      // owner kept: quota count advances

    assign owner_req  = |(MADDRSEL & grant_q);
    assign owner_lock = |(MLOCK & grant_q);
    assign other_req  = |(MADDRSEL & ~grant_q);

    // The current owner is excluded so a handover always moves to someone else;
    // in IDLE grant_q is empty and nothing is excluded.
    coreahblite_rr_picker u_picker (
        .req     (MADDRSEL),
        .ptr     (ptr_q),
        .exclude (grant_q),
        .winner  (pick),
        .valid   (pick_valid)
    );

`ifdef COREAHBLITE_ARB_QUOTA_EN
    localparam logic [CNT_W-1:0] QUOTA_C = CNT_W'(QUOTA);

    logic [CNT_W-1:0] count_q;

    assign quota_left = (count_q < QUOTA_C);

    // Consecutive address phases granted to the current owner, saturating at QUOTA.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            count_q <= '0;
        end else if (load_one) begin
            count_q <= CNT_W'(1);
        end else if (bump && (count_q != QUOTA_C)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end
`else
    // Quota of one: the owner keeps the slave only while nobody else waits.
    assign quota_left = 1'b0;

    logic unused_quota;
    assign unused_quota = ^{load_one, bump, CNT_W'(QUOTA)};
`endif

    // Next-state, next-grant and pointer update at arbitration events.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        load_one = 1'b0;
        bump     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d  = pick;
                    ptr_d    = onehot_to_idx(pick);
                    load_one = 1'b1;
                    state_d  = (|(MLOCK & pick)) ? ST_LOCKED : ST_OWNED;
                end
            end
            ST_OWNED, ST_LOCKED: begin
                if (ADDRPHEND) begin
                    if (owner_lock) begin
                        // Locked sequence: hold the grant, quota count frozen.
                        state_d = ST_LOCKED;
                    end else if (owner_req && (!other_req || quota_left)) begin
                        state_d = ST_OWNED;
                        bump    = 1'b1;
                    end else if (pick_valid) begin
                        grant_d  = pick;
                        ptr_d    = onehot_to_idx(pick);
                        load_one = 1'b1;
                        state_d  = ST_OWNED;
                    end else begin
                        grant_d = MASTER_NONE;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                grant_d = MASTER_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, pointer and LOCKED registers.
    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (HRESET) begin
            state_q  <= ST_IDLE;
            grant_q  <= MASTER_NONE;
            ptr_q    <= IDX_W'(NUM_MASTERS - 1);
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            locked_q <= (state_d == ST_LOCKED);
        end
    end

    assign MASTERADDRINPROG = grant_q;
    assign LOCKED           = locked_q;

endmodule

// File: tb/tb_coreahblite_slave_rr_arbiter.sv
// Self-checking bench for coreahblite_slave_rr_arbiter: directed scenarios
// plus randomized traffic against a behavioural ownership model.
module tb_coreahblite_slave_rr_arbiter;

    localparam int QUOTA = 4;
`ifdef COREAHBLITE_ARB_QUOTA_EN
    localparam int EFF_QUOTA = QUOTA;
`else
    localparam int EFF_QUOTA = 1;
`endif

    logic       HCLK;
    logic       HRESET;
    logic [3:0] MADDRSEL;
    logic [3:0] MLOCK;
    logic       ADDRPHEND;
    logic [3:0] MASTERADDRINPROG;
    logic       LOCKED;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: who owns the slave, lock flag, last winner, phases used.
    int m_owner  = -1;
    bit m_locked = 1'b0;
    int m_ptr    = 3;
    int m_count  = 0;

    coreahblite_slave_rr_arbiter #(.QUOTA(QUOTA)) dut (
        .HCLK             (HCLK),
        .HRESET           (HRESET),
        .MADDRSEL         (MADDRSEL),
        .MLOCK            (MLOCK),
        .ADDRPHEND        (ADDRPHEND),
        .MASTERADDRINPROG (MASTERADDRINPROG),
        .LOCKED           (LOCKED)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // First requester after ptr in circular order, or -1.
    function automatic int rr_pick(input logic [3:0] req, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (ptr + k) % 4;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] req,
                              input logic [3:0] lock, input logic phend);
        int w;
        logic [3:0] others;
        if (rst) begin
            m_owner = -1; m_locked = 1'b0; m_ptr = 3; m_count = 0;
        end else if (m_owner < 0) begin
            w = rr_pick(req, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_ptr = w; m_count = 1; m_locked = lock[w];
            end
        end else if (phend) begin
            others = req & ~4'(1 << m_owner);
            if (lock[m_owner]) begin
                m_locked = 1'b1;
            end else if (req[m_owner] && (others == 4'b0000 || m_count < EFF_QUOTA)) begin
                m_locked = 1'b0;
                if (m_count < EFF_QUOTA) m_count++;
            end else if (others != 4'b0000) begin
                w = rr_pick(others, m_ptr);
                m_owner = w; m_ptr = w; m_count = 1; m_locked = 1'b0;
            end else begin
                m_owner = -1; m_locked = 1'b0;
            end
        end
    endtask

    // Apply inputs for one clock, advance the model, sample 1 time unit after the edge.
    task automatic drive_edge(input logic rst, input logic [3:0] req,
                              input logic [3:0] lock, input logic phend);
        HRESET = rst; MADDRSEL = req; MLOCK = lock; ADDRPHEND = phend;
        @(posedge HCLK);
        model_step(rst, req, lock, phend);
        #1;
    endtask

    task automatic test_reset();
        drive_edge(1'b1, 4'b1111, 4'b1111, 1'b1);
        drive_edge(1'b1, 4'b0110, 4'b0000, 1'b0);
        n_checks++;
        if (MASTERADDRINPROG !== 4'b0000 || LOCKED !== 1'b0)
            $display("FAIL reset: grant=%b locked=%b expected grant=0000 locked=0",
                     MASTERADDRINPROG, LOCKED);
        else n_pass++;
    endtask

    // Two masters held requesting with ADDRPHEND every cycle: ownership
    // alternates in blocks of EFF_QUOTA cycles, first owner per round-robin.
    task automatic test_rotation(input logic [3:0] req, input logic [3:0] first,
                                 input logic [3:0] second);
        logic [3:0] exp;
        drive_edge(1'b1, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 4 * EFF_QUOTA + 2; i++) begin
            drive_edge(1'b0, req, 4'b0000, 1'b1);
            exp = (((i / EFF_QUOTA) % 2) == 0) ? first : second;
            n_checks++;
            if (MASTERADDRINPROG !== exp || LOCKED !== 1'b0)
                $display("FAIL rotation req=%b cycle %0d: grant=%b locked=%b expected grant=%b locked=0",
                         req, i, MASTERADDRINPROG, LOCKED, exp);
            else n_pass++;
        end
    endtask

    task automatic test_lock();
        drive_edge(1'b1, 4'b0000, 4'b0000, 1'b0);
        drive_edge(1'b0, 4'b0100, 4'b0100, 1'b1);
        n_checks++;
        if (MASTERADDRINPROG !== 4'b0100 || LOCKED !== 1'b1)
            $display("FAIL lock_grant: grant=%b locked=%b expected grant=0100 locked=1",
                     MASTERADDRINPROG, LOCKED);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            drive_edge(1'b0, 4'b1111, 4'b0100, 1'b1);
            n_checks++;
            if (MASTERADDRINPROG !== 4'b0100 || LOCKED !== 1'b1)
                $display("FAIL lock_hold %0d: grant=%b locked=%b expected grant=0100 locked=1",
                         i, MASTERADDRINPROG, LOCKED);
            else n_pass++;
        end
        // Lock released: the locked phase counted as one, remaining quota is used first.
        for (int i = 0; i < EFF_QUOTA - 1; i++) begin
            drive_edge(1'b0, 4'b1111, 4'b0000, 1'b1);
            n_checks++;
            if (MASTERADDRINPROG !== 4'b0100 || LOCKED !== 1'b0)
                $display("FAIL lock_quota %0d: grant=%b locked=%b expected grant=0100 locked=0",
                         i, MASTERADDRINPROG, LOCKED);
            else n_pass++;
        end
        drive_edge(1'b0, 4'b1111, 4'b0000, 1'b1);
        n_checks++;
        if (MASTERADDRINPROG !== 4'b1000 || LOCKED !== 1'b0)
            $display("FAIL lock_release: grant=%b locked=%b expected grant=1000 locked=0",
                     MASTERADDRINPROG, LOCKED);
        else n_pass++;
    endtask

    task automatic test_hold_until_phend();
        drive_edge(1'b1, 4'b0000, 4'b0000, 1'b0);
        drive_edge(1'b0, 4'b0010, 4'b0000, 1'b0);
        n_checks++;
        if (MASTERADDRINPROG !== 4'b0010)
            $display("FAIL idle_grant: grant=%b expected 0010", MASTERADDRINPROG);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 4'b0000, 4'b0000, 1'b0);
            n_checks++;
            if (MASTERADDRINPROG !== 4'b0010)
                $display("FAIL hold_no_phend %0d: grant=%b expected 0010", i, MASTERADDRINPROG);
            else n_pass++;
        end
        drive_edge(1'b0, 4'b0000, 4'b0000, 1'b1);
        n_checks++;
        if (MASTERADDRINPROG !== 4'b0000 || LOCKED !== 1'b0)
            $display("FAIL release_idle: grant=%b locked=%b expected grant=0000 locked=0",
                     MASTERADDRINPROG, LOCKED);
        else n_pass++;
        // Only IDLE grants without ADDRPHEND, so this also confirms the return to IDLE.
        drive_edge(1'b0, 4'b0001, 4'b0000, 1'b0);
        n_checks++;
        if (MASTERADDRINPROG !== 4'b0001)
            $display("FAIL idle_regrant: grant=%b expected 0001", MASTERADDRINPROG);
        else n_pass++;
    endtask

    task automatic test_reset_while_locked();
        drive_edge(1'b1, 4'b0000, 4'b0000, 1'b0);
        drive_edge(1'b0, 4'b1000, 4'b1000, 1'b1);
        drive_edge(1'b0, 4'b1111, 4'b1000, 1'b1);
        n_checks++;
        if (MASTERADDRINPROG !== 4'b1000 || LOCKED !== 1'b1)
            $display("FAIL lock_owner3: grant=%b locked=%b expected grant=1000 locked=1",
                     MASTERADDRINPROG, LOCKED);
        else n_pass++;
        drive_edge(1'b1, 4'b1111, 4'b1111, 1'b1);
        n_checks++;
        if (MASTERADDRINPROG !== 4'b0000 || LOCKED !== 1'b0)
            $display("FAIL reset_locked: grant=%b locked=%b expected grant=0000 locked=0",
                     MASTERADDRINPROG, LOCKED);
        else n_pass++;
        drive_edge(1'b0, 4'b1111, 4'b0000, 1'b0);
        n_checks++;
        if (MASTERADDRINPROG !== 4'b0001 || LOCKED !== 1'b0)
            $display("FAIL post_reset_priority: grant=%b locked=%b expected grant=0001 locked=0",
                     MASTERADDRINPROG, LOCKED);
        else n_pass++;
    endtask

    // Random requests, locks, phase ends and occasional resets against the model.
    task automatic test_random(input int cycles);
        logic       rst;
        logic [3:0] req, lock;
        logic       phend;
        for (int i = 0; i < cycles; i++) begin
            rst   = ($urandom_range(0, 63) == 0);
            req   = 4'($urandom_range(0, 15));
            lock  = 4'($urandom & $urandom);
            phend = ($urandom_range(0, 9) < 7);
            drive_edge(rst, req, lock, phend);
            n_checks++;
            if (MASTERADDRINPROG !== exp_grant() || LOCKED !== m_locked)
                $display("FAIL random %0d: grant=%b locked=%b expected grant=%b locked=%b",
                         i, MASTERADDRINPROG, LOCKED, exp_grant(), m_locked);
            else n_pass++;
            n_checks++;
            if ($countones(MASTERADDRINPROG) > 1)
                $display("FAIL onehot %0d: grant=%b expected at most one bit",
                         i, MASTERADDRINPROG);
            else n_pass++;
        end
    endtask

    initial begin
        HRESET = 1'b1; MADDRSEL = 4'b0000; MLOCK = 4'b0000; ADDRPHEND = 1'b0;
        test_reset();
        test_rotation(4'b1010, 4'b0010, 4'b1000);
        test_rotation(4'b0011, 4'b0001, 4'b0010);
        test_lock();
        test_hold_until_phend();
        test_reset_while_locked();
        test_random(2000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
